// File: rtl/mem_arbiter.sv
// Shared-RAM arbiter between icache fetches and dcache reads/writes.
// One grant is held for a whole RAM transaction; the requester is released on ACCESS.
module mem_arbiter #(
    parameter bit FAIR   = 1'b1,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef logic [ADDR_W-1:0] word_t;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IGRANT = 2'd1;
    localparam logic [1:0] DGRANT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       last_was_data;
    logic       next_last;
    logic       ram_done;

    assign iload    = ramload;
    assign dload    = ramload;
    assign ram_done = (ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= IDLE;
            last_was_data <= 1'b0;
        end else begin
            state         <= next_state;
            last_was_data <= next_last;
        end
    end

    always_comb begin
        next_state = state;
        next_last  = last_was_data;
        iwait      = 1'b1;
        dwait      = 1'b1;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = word_t'(0);
        ramstore   = word_t'(0);

        case (state)
            IDLE: begin
                if (FAIR && last_was_data && iREN) begin
                    next_state = IGRANT;
                end else if (dREN || dWEN) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end

            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                // A dropped request aborts the grant without releasing iwait.
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ram_done) begin
                    iwait      = 1'b0;
                    next_state = IDLE;
                    next_last  = 1'b0;
                end
            end

            DGRANT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = dREN;
                end
                if (!(dREN || dWEN)) begin
                    next_state = IDLE;
                end else if (ram_done) begin
                    dwait      = 1'b0;
                    next_state = IDLE;
                    next_last  = 1'b1;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a FAIR=1 and a FAIR=0 instance share stimulus, each with
// its own latency-programmable RAM responder and a port-ownership reference model.
module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    localparam int NONE = 0;
    localparam int ISIDE = 1;
    localparam int DSIDE = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;

    logic        iwait_w    [2];
    logic [31:0] iload_w    [2];
    logic        dwait_w    [2];
    logic [31:0] dload_w    [2];
    logic        ramREN_w   [2];
    logic        ramWEN_w   [2];
    logic [31:0] ramaddr_w  [2];
    logic [31:0] ramstore_w [2];
    logic [31:0] ramload_w  [2] = '{32'h0, 32'h0};
    logic [1:0]  ramstate_w [2] = '{FREE, FREE};

    int checks = 0;
    int failures = 0;
    int lat = 1;
    bit err = 1'b0;
    int cnt [2] = '{0, 0};
    int log_q0 [$];
    int log_q1 [$];

    // Instance 0 is fair, instance 1 gives the data side fixed priority.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.FAIR(g == 0), .ADDR_W(32)) dut (
            .CLK(CLK), .nRST(nRST),
            .iREN(iREN), .iaddr(iaddr), .iwait(iwait_w[g]), .iload(iload_w[g]),
            .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
            .dwait(dwait_w[g]), .dload(dload_w[g]),
            .ramREN(ramREN_w[g]), .ramWEN(ramWEN_w[g]), .ramaddr(ramaddr_w[g]),
            .ramstore(ramstore_w[g]), .ramload(ramload_w[g]), .ramstate(ramstate_w[g])
        );
    end

    initial forever #5 CLK = ~CLK;

    function automatic logic [31:0] rdata(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2001_0005;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [31:0] ds);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic probe();
        @(negedge CLK);
        #2;
    endtask

    // RAM responder: answers ACCESS on the lat-th consecutive strobe cycle.
    initial forever begin
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            if (!(ramREN_w[k] || ramWEN_w[k])) begin
                cnt[k] = 0;
                ramstate_w[k] = FREE;
            end else begin
                cnt[k]++;
                if (err) ramstate_w[k] = ERROR;
                else if (cnt[k] >= lat) ramstate_w[k] = ACCESS;
                else ramstate_w[k] = BUSY;
            end
            ramload_w[k] = rdata(ramaddr_w[k]);
        end
    end

    // Reference model: tracks which side owns the RAM port and checks every cycle.
    initial begin
        int owner [2];
        bit lastd [2];
        owner = '{NONE, NONE};
        lastd = '{1'b0, 1'b0};
        forever begin
            @(negedge CLK);
            #1;
            for (int k = 0; k < 2; k++) begin
                logic eiw, edw, er, ew;
                logic [31:0] ea, es;
                bit acc;
                string p;
                p = $sformatf("dut%0d t=%0t", k, $time);
                acc = (ramstate_w[k] == ACCESS);
                if (!nRST) begin
                    owner[k] = NONE;
                    lastd[k] = 1'b0;
                end
                eiw = 1'b1; edw = 1'b1; er = 1'b0; ew = 1'b0; ea = '0; es = '0;
                if (owner[k] == ISIDE) begin
                    er = iREN; ea = iaddr;
                    if (iREN && acc) eiw = 1'b0;
                end else if (owner[k] == DSIDE) begin
                    ea = daddr;
                    if (dWEN) begin ew = 1'b1; es = dstore; end
                    else er = dREN;
                    if ((dREN || dWEN) && acc) edw = 1'b0;
                end
                checkOutput({p, " iwait"},    32'(iwait_w[k]),  32'(eiw));
                checkOutput({p, " dwait"},    32'(dwait_w[k]),  32'(edw));
                checkOutput({p, " ramREN"},   32'(ramREN_w[k]), 32'(er));
                checkOutput({p, " ramWEN"},   32'(ramWEN_w[k]), 32'(ew));
                checkOutput({p, " ramaddr"},  ramaddr_w[k],     ea);
                checkOutput({p, " ramstore"}, ramstore_w[k],    es);
                if (!eiw) checkOutput({p, " iload"}, iload_w[k], rdata(iaddr));
                if (!edw && !dWEN) checkOutput({p, " dload"}, dload_w[k], rdata(daddr));
                if (!iwait_w[k]) begin if (k == 0) log_q0.push_back(ISIDE); else log_q1.push_back(ISIDE); end
                if (!dwait_w[k]) begin if (k == 0) log_q0.push_back(DSIDE); else log_q1.push_back(DSIDE); end
                if (nRST) begin
                    case (owner[k])
                        NONE: begin
                            if ((k == 0) && lastd[k] && iREN) owner[k] = ISIDE;
                            else if (dREN || dWEN) owner[k] = DSIDE;
                            else if (iREN) owner[k] = ISIDE;
                        end
                        ISIDE: begin
                            if (!iREN) owner[k] = NONE;
                            else if (acc) begin owner[k] = NONE; lastd[k] = 1'b0; end
                        end
                        default: begin
                            if (!(dREN || dWEN)) owner[k] = NONE;
                            else if (acc) begin owner[k] = NONE; lastd[k] = 1'b1; end
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) tick();
        probe();
        checkOutput("reset iwait", 32'(iwait_w[0]), 32'd1);
        checkOutput("reset dwait", 32'(dwait_w[0]), 32'd1);
        checkOutput("reset ramREN", 32'(ramREN_w[0]), 32'd0);
        checkOutput("reset ramWEN", 32'(ramWEN_w[0]), 32'd0);
        checkOutput("reset ramaddr", ramaddr_w[0], 32'd0);
        tick();
        nRST = 1'b1;

        // Single fetch, ACCESS on the second grant cycle
        tick(); lat = 2; applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        probe();
        checkOutput("s1 idle ramREN", 32'(ramREN_w[0]), 32'd0);
        checkOutput("s1 idle iwait", 32'(iwait_w[0]), 32'd1);
        tick(); probe();
        checkOutput("s1 g1 ramREN", 32'(ramREN_w[0]), 32'd1);
        checkOutput("s1 g1 ramaddr", ramaddr_w[0], 32'h40);
        checkOutput("s1 g1 iwait", 32'(iwait_w[0]), 32'd1);
        tick(); probe();
        checkOutput("s1 g2 iwait", 32'(iwait_w[0]), 32'd0);
        checkOutput("s1 g2 iload", iload_w[0], 32'h2001_0005);
        tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        probe();
        checkOutput("s1 done iwait", 32'(iwait_w[0]), 32'd1);
        checkOutput("s1 done ramREN", 32'(ramREN_w[0]), 32'd0);

        // Contention, three-cycle RAM accesses
        tick(); lat = 3; log_q0.delete(); log_q1.delete();
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h180, 32'h0);
        repeat (12) tick();
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        probe();
        checkOutput("s3 fair count", 32'(log_q0.size()), 32'd4);
        checkOutput("s3 fair order0", 32'(log_q0[0]), 32'(DSIDE));
        checkOutput("s3 fair order1", 32'(log_q0[1]), 32'(ISIDE));
        checkOutput("s3 fair order2", 32'(log_q0[2]), 32'(DSIDE));
        checkOutput("s3 fair order3", 32'(log_q0[3]), 32'(ISIDE));
        checkOutput("s3 fixed count", 32'(log_q1.size()), 32'd4);
        checkOutput("s3 fixed order0", 32'(log_q1[0]), 32'(DSIDE));
        checkOutput("s3 fixed order1", 32'(log_q1[1]), 32'(DSIDE));
        checkOutput("s3 fixed order2", 32'(log_q1[2]), 32'(DSIDE));
        checkOutput("s3 fixed order3", 32'(log_q1[3]), 32'(ISIDE));

        // ERROR retried, then the fetch is abandoned
        tick(); lat = 1; err = 1'b1; log_q0.delete(); log_q1.delete();
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);
        probe();
        for (int c = 0; c < 5; c++) begin
            tick(); probe();
            checkOutput($sformatf("s4 err%0d iwait", c), 32'(iwait_w[0]), 32'd1);
            checkOutput($sformatf("s4 err%0d ramREN", c), 32'(ramREN_w[0]), 32'd1);
        end
        tick(); err = 1'b0; applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h1C0, 32'h0);
        probe();
        checkOutput("s4 abort ramREN", 32'(ramREN_w[0]), 32'd0);
        checkOutput("s4 abort iwait", 32'(iwait_w[0]), 32'd1);
        tick(); probe();
        checkOutput("s4 idle ramREN", 32'(ramREN_w[0]), 32'd0);
        tick(); probe();
        checkOutput("s4 dgrant ramaddr", ramaddr_w[0], 32'h1C0);
        checkOutput("s4 dgrant dwait", 32'(dwait_w[0]), 32'd0);
        tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("s4 release count", 32'(log_q0.size()), 32'd1);
        checkOutput("s4 release side", 32'(log_q0[0]), 32'(DSIDE));

        // Asynchronous reset during a BUSY data read
        tick(); lat = 5; applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        probe();
        tick(); probe();
        checkOutput("s5 busy ramREN", 32'(ramREN_w[0]), 32'd1);
        tick(); probe();
        #1 nRST = 1'b0;
        #1;
        checkOutput("s5 async ramREN", 32'(ramREN_w[0]), 32'd0);
        checkOutput("s5 async ramWEN", 32'(ramWEN_w[0]), 32'd0);
        checkOutput("s5 async dwait", 32'(dwait_w[0]), 32'd1);
        checkOutput("s5 async iwait", 32'(iwait_w[0]), 32'd1);
        tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); nRST = 1'b1; lat = 1;
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
        probe();
        checkOutput("s5 refetch idle iwait", 32'(iwait_w[0]), 32'd1);
        tick(); probe();
        checkOutput("s5 refetch iwait", 32'(iwait_w[0]), 32'd0);
        checkOutput("s5 refetch iload", iload_w[0], 32'h5A5A_0300);
        tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Write with dREN also high is a write
        tick(); lat = 1; log_q0.delete();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        probe();
        checkOutput("s2 idle ramWEN", 32'(ramWEN_w[0]), 32'd0);
        tick(); probe();
        checkOutput("s2 ramWEN", 32'(ramWEN_w[0]), 32'd1);
        checkOutput("s2 ramREN", 32'(ramREN_w[0]), 32'd0);
        checkOutput("s2 ramstore", ramstore_w[0], 32'hDEAD_BEEF);
        checkOutput("s2 ramaddr", ramaddr_w[0], 32'h100);
        checkOutput("s2 dwait", 32'(dwait_w[0]), 32'd0);
        checkOutput("s2 iwait", 32'(iwait_w[0]), 32'd1);
        tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        probe();
        checkOutput("s2 done dwait", 32'(dwait_w[0]), 32'd1);
        checkOutput("s2 done ramWEN", 32'(ramWEN_w[0]), 32'd0);
        checkOutput("s2 pulse count", 32'(log_q0.size()), 32'd1);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
